// File: rtl/fetch_queue_unit_if.sv
// fetch_queue_unit_if: instruction-memory, BTB, redirect and decode signals of the fetch stage.
// The perf counter signals exist only when FETCH_PERF_CNT_EN is defined.
interface fetch_queue_unit_if #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int FETCH_WIDTH = 2,
    parameter int QUEUE_DEPTH = 8
);
    localparam int SW = FETCH_WIDTH > 1 ? $clog2(FETCH_WIDTH) : 1;
    localparam int CW = $clog2(QUEUE_DEPTH) + 1;
    logic                              imem_req_valid;
    logic                              imem_req_ready;
    logic [ADDR_WIDTH-1:0]             imem_req_addr;
    logic                              imem_resp_valid;
    logic [FETCH_WIDTH*DATA_WIDTH-1:0] imem_resp_data;
    logic                              bp_hit;
    logic [SW-1:0]                     bp_slot;
    logic [ADDR_WIDTH-1:0]             bp_target;
    logic                              redirect_valid;
    logic [ADDR_WIDTH-1:0]             redirect_pc;
    logic [FETCH_WIDTH-1:0]            dec_valid;
    logic                              dec_ready;
    logic [FETCH_WIDTH*DATA_WIDTH-1:0] dec_instr;
    logic [FETCH_WIDTH*ADDR_WIDTH-1:0] dec_pc;
    logic [FETCH_WIDTH-1:0]            dec_pred_taken;
    logic [FETCH_WIDTH*ADDR_WIDTH-1:0] dec_pred_target;
    logic [CW-1:0]                     queue_count;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0]                       perf_stall_full;
    logic [31:0]                       perf_dropped;
    logic [31:0]                       perf_fetched;
`endif
    modport master (
`ifdef FETCH_PERF_CNT_EN
        output perf_stall_full, perf_dropped, perf_fetched,
`endif
        output imem_req_valid, imem_req_addr, dec_valid, dec_instr, dec_pc,
               dec_pred_taken, dec_pred_target, queue_count,
        input  imem_req_ready, imem_resp_valid, imem_resp_data, bp_hit, bp_slot,
               bp_target, redirect_valid, redirect_pc, dec_ready
    );
    modport slave (
`ifdef FETCH_PERF_CNT_EN
        input  perf_stall_full, perf_dropped, perf_fetched,
`endif
        input  imem_req_valid, imem_req_addr, dec_valid, dec_instr, dec_pc,
               dec_pred_taken, dec_pred_target, queue_count,
        output imem_req_ready, imem_resp_valid, imem_resp_data, bp_hit, bp_slot,
               bp_target, redirect_valid, redirect_pc, dec_ready
    );
endinterface

// File: rtl/fetch_queue_unit.sv
// fetch_queue_unit: N-wide fetch stage with BTB block truncation, fetch queue and redirect handling.
// Optional FETCH_PERF_CNT_EN adds saturating stall/drop/fetch counters.
module fetch_queue_unit #(
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    FETCH_WIDTH = 2,
    parameter int                    QUEUE_DEPTH = 8,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0
) (
    input logic                clk,
    input logic                rst,
    fetch_queue_unit_if.master bus
);
    localparam int SW = FETCH_WIDTH > 1 ? $clog2(FETCH_WIDTH) : 1;
    localparam int QW = $clog2(QUEUE_DEPTH);
    localparam int CW = QW + 1;
    localparam logic [ADDR_WIDTH-1:0] BLK_BYTES = ADDR_WIDTH'(4 * FETCH_WIDTH);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DROP} state_t;

    state_t                r_state, w_next;
    logic [ADDR_WIDTH-1:0] r_pc, r_blk_pc, r_bp_target;
    logic                  r_bp_hit;
    logic [SW-1:0]         r_bp_slot;
    logic [DATA_WIDTH-1:0] r_q_instr [QUEUE_DEPTH];
    logic [ADDR_WIDTH-1:0] r_q_pc    [QUEUE_DEPTH];
    logic [ADDR_WIDTH-1:0] r_q_tgt   [QUEUE_DEPTH];
    logic [QUEUE_DEPTH-1:0] r_q_taken;
    logic [QW-1:0]         r_head, r_tail;
    logic [CW-1:0]         r_count;
    logic                  w_accept, w_enq, w_deq, w_space_ok;
    logic [CW-1:0]         w_n_enq, w_n_deq, w_add, w_sub;

    assign w_accept   = r_state == REQ && bus.imem_req_ready;
    assign w_enq      = r_state == WAIT && bus.imem_resp_valid && !bus.redirect_valid;
    assign w_deq      = bus.dec_ready && r_count != '0 && !bus.redirect_valid;
    assign w_space_ok = CW'(QUEUE_DEPTH) - r_count >= CW'(FETCH_WIDTH);
    assign w_n_enq    = r_bp_hit ? CW'(r_bp_slot) + CW'(1) : CW'(FETCH_WIDTH);
    assign w_n_deq    = r_count >= CW'(FETCH_WIDTH) ? CW'(FETCH_WIDTH) : r_count;
    assign w_add      = w_enq ? w_n_enq : '0;
    assign w_sub      = w_deq ? w_n_deq : '0;

    // A response that races a redirect is consumed here, so a WAIT+resp redirect returns to IDLE.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = (!bus.redirect_valid && w_space_ok) ? REQ : IDLE;
            REQ:     w_next = bus.imem_req_ready ? (bus.redirect_valid ? DROP : WAIT)
                                                 : (bus.redirect_valid ? IDLE : REQ);
            WAIT:    w_next = bus.imem_resp_valid ? IDLE : (bus.redirect_valid ? DROP : WAIT);
            DROP:    w_next = bus.imem_resp_valid ? IDLE : DROP;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_pc        <= RESET_PC;
            r_blk_pc    <= '0;
            r_bp_hit    <= 1'b0;
            r_bp_slot   <= '0;
            r_bp_target <= '0;
            r_head      <= '0;
            r_tail      <= '0;
            r_count     <= '0;
        end else begin
            r_state <= w_next;
            r_pc    <= bus.redirect_valid ? bus.redirect_pc
                     : w_accept ? (bus.bp_hit ? bus.bp_target : r_pc + BLK_BYTES) : r_pc;
            if (w_accept) begin
                r_blk_pc    <= r_pc;
                r_bp_hit    <= bus.bp_hit;
                r_bp_slot   <= bus.bp_slot;
                r_bp_target <= bus.bp_target;
            end
            r_head  <= bus.redirect_valid ? r_tail : r_head + QW'(w_sub);
            r_tail  <= r_tail + QW'(w_add);
            r_count <= bus.redirect_valid ? '0 : r_count + w_add - w_sub;
        end
    end

    // Storage is not reset: lanes beyond the occupancy are masked to zero.
    always_ff @(posedge clk) begin
        if (w_enq) begin
            for (int j = 0; j < FETCH_WIDTH; j++) begin
                if (CW'(j) < w_n_enq) begin
                    r_q_instr[r_tail + QW'(j)] <= bus.imem_resp_data[j*DATA_WIDTH +: DATA_WIDTH];
                    r_q_pc[r_tail + QW'(j)]    <= r_blk_pc + ADDR_WIDTH'(4 * j);
                    r_q_taken[r_tail + QW'(j)] <= r_bp_hit && SW'(j) == r_bp_slot;
                    r_q_tgt[r_tail + QW'(j)]   <= (r_bp_hit && SW'(j) == r_bp_slot) ? r_bp_target : '0;
                end
            end
        end
    end

    assign bus.imem_req_valid = r_state == REQ;
    assign bus.imem_req_addr  = r_state == REQ ? r_pc : '0;
    assign bus.queue_count    = r_count;

    for (genvar i = 0; i < FETCH_WIDTH; i++) begin : g_lane
        logic [QW-1:0] w_idx;
        logic          w_v;
        assign w_idx = r_head + QW'(i);
        assign w_v   = CW'(i) < r_count;
        assign bus.dec_valid[i]                                 = w_v;
        assign bus.dec_instr[i*DATA_WIDTH +: DATA_WIDTH]        = w_v ? r_q_instr[w_idx] : '0;
        assign bus.dec_pc[i*ADDR_WIDTH +: ADDR_WIDTH]           = w_v ? r_q_pc[w_idx] : '0;
        assign bus.dec_pred_taken[i]                            = w_v && r_q_taken[w_idx];
        assign bus.dec_pred_target[i*ADDR_WIDTH +: ADDR_WIDTH]  = w_v ? r_q_tgt[w_idx] : '0;
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] r_stall, r_dropped, r_fetched;
    logic [32:0] w_fetch_sum;
    logic        w_drop_ev;
    assign w_fetch_sum = {1'b0, r_fetched} + 33'(w_add);
    assign w_drop_ev   = bus.imem_resp_valid && (r_state == DROP || (r_state == WAIT && bus.redirect_valid));
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall   <= '0;
            r_dropped <= '0;
            r_fetched <= '0;
        end else begin
            r_stall   <= (r_state == IDLE && !w_space_ok && r_stall != '1) ? r_stall + 32'd1 : r_stall;
            r_dropped <= (w_drop_ev && r_dropped != '1) ? r_dropped + 32'd1 : r_dropped;
            r_fetched <= w_fetch_sum[32] ? '1 : w_fetch_sum[31:0];
        end
    end
    assign bus.perf_stall_full = r_stall;
    assign bus.perf_dropped    = r_dropped;
    assign bus.perf_fetched    = r_fetched;
`endif
endmodule

// File: tb/tb_fetch_queue_unit.sv
// tb_fetch_queue_unit: directed scenarios plus randomized traffic against a transaction-level model.
module tb_fetch_queue_unit;
    localparam int AW = 32, DW = 32, FW = 2, QD = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    fetch_queue_unit_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FETCH_WIDTH(FW), .QUEUE_DEPTH(QD)) bus ();
    fetch_queue_unit #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FETCH_WIDTH(FW), .QUEUE_DEPTH(QD), .RESET_PC('0))
        dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        logic [AW-1:0] pc;
        logic [DW-1:0] instr;
        logic          taken;
        logic [AW-1:0] tgt;
    } entry_t;

    int tests = 0, fails = 0;
    entry_t exq[$];
    entry_t dec_log[$];
    logic [FW-1:0] mask_log[$];
    logic [AW-1:0] req_log[$];
    int p_ready, lat_min, lat_max, p_dec, p_redir, bp_mode;
    bit force_redir, redir_on_resp, redir_on_req;
    logic [AW-1:0] redir_pc;
    bit mem_busy;
    int mem_lat;
    logic [AW-1:0] mem_addr;
    logic [AW-1:0] m_pc, m_blk, m_tgt, prev_addr;
    bit m_out, m_drop, m_hit, prev_stall;
    logic m_slot;

    function automatic logic [DW-1:0] instr_of(input logic [AW-1:0] a);
        return a * 32'h9E3779B1 + 32'h1357;
    endfunction

    always_comb begin
        bus.bp_hit    = 1'b0;
        bus.bp_slot   = 1'b0;
        bus.bp_target = '0;
        if (bp_mode == 1 && bus.imem_req_addr == 32'h8) begin
            bus.bp_hit    = 1'b1;
            bus.bp_target = 32'h100;
        end else if (bp_mode == 2 && bus.imem_req_addr[5:3] == 3'b011) begin
            bus.bp_hit    = 1'b1;
            bus.bp_slot   = bus.imem_req_addr[6];
            bus.bp_target = {bus.imem_req_addr[31:10] + 22'd1, bus.imem_req_addr[9:2] ^ 8'h35, 2'b00};
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        exq.delete();
        m_pc = '0; m_out = 0; m_drop = 0; prev_stall = 0;
    endtask

    task automatic drive();
        bus.imem_resp_valid = mem_busy && mem_lat == 0;
        for (int i = 0; i < FW; i++)
            bus.imem_resp_data[i*DW +: DW] = bus.imem_resp_valid ? instr_of(mem_addr + AW'(4 * i)) : $urandom;
        bus.imem_req_ready = !mem_busy && $urandom_range(99) < p_ready;
        bus.dec_ready      = $urandom_range(99) < p_dec;
        bus.redirect_pc    = $urandom & 32'hFFFF_FFFC;
        bus.redirect_valid = $urandom_range(999) < p_redir;
        if (force_redir || (redir_on_resp && bus.imem_resp_valid) ||
            (redir_on_req && bus.imem_req_valid && bus.imem_req_ready)) begin
            bus.redirect_valid = 1'b1;
            bus.redirect_pc    = redir_pc;
            force_redir = 0; redir_on_resp = 0; redir_on_req = 0;
        end
    endtask

    task automatic observe();
        int n;
        bit acc;
        n = exq.size() < FW ? exq.size() : FW;
        acc = bus.imem_req_valid && bus.imem_req_ready;
        chk("queue_count", bus.queue_count, exq.size());
        for (int i = 0; i < FW; i++) begin
            entry_t e;
            e.pc = '0; e.instr = '0; e.taken = 1'b0; e.tgt = '0;
            if (i < n) e = exq[i];
            chk($sformatf("dec_valid%0d", i), bus.dec_valid[i], i < n);
            chk($sformatf("dec_pc%0d", i), bus.dec_pc[i*AW +: AW], e.pc);
            chk($sformatf("dec_instr%0d", i), bus.dec_instr[i*DW +: DW], e.instr);
            chk($sformatf("dec_taken%0d", i), bus.dec_pred_taken[i], e.taken);
            chk($sformatf("dec_target%0d", i), bus.dec_pred_target[i*AW +: AW], e.tgt);
        end
        if (bus.imem_req_valid) begin
            chk("req_addr", bus.imem_req_addr, m_pc);
            chk("req_space", QD - exq.size() >= FW, 1);
            chk("req_single_outstanding", m_out, 0);
        end else begin
            chk("req_addr_idle", bus.imem_req_addr, 0);
        end
        if (prev_stall) chk("req_held", {bus.imem_req_valid, bus.imem_req_addr}, {1'b1, prev_addr});
        prev_stall = bus.imem_req_valid && !bus.imem_req_ready && !bus.redirect_valid;
        prev_addr  = bus.imem_req_addr;
        if (acc) req_log.push_back(bus.imem_req_addr);
        if (bus.redirect_valid) begin
            exq.delete();
            m_pc = bus.redirect_pc;
            if (m_out && bus.imem_resp_valid) m_out = 0;
            else if (m_out) m_drop = 1;
            if (acc) begin m_out = 1; m_drop = 1; end
        end else begin
            if (bus.dec_ready && n > 0) begin
                entry_t d;
                d.pc = bus.dec_pc[AW-1:0]; d.instr = bus.dec_instr[DW-1:0];
                d.taken = bus.dec_pred_taken[0]; d.tgt = bus.dec_pred_target[AW-1:0];
                dec_log.push_back(d);
                mask_log.push_back(bus.dec_valid);
                repeat (n) void'(exq.pop_front());
            end
            if (m_out && bus.imem_resp_valid) begin
                if (!m_drop) begin
                    for (int j = 0; j <= (m_hit ? int'(m_slot) : FW - 1); j++) begin
                        entry_t e;
                        e.pc    = m_blk + AW'(4 * j);
                        e.instr = instr_of(e.pc);
                        e.taken = m_hit && j == int'(m_slot);
                        e.tgt   = e.taken ? m_tgt : '0;
                        exq.push_back(e);
                    end
                end
                m_out = 0; m_drop = 0;
            end
            if (acc) begin
                m_out = 1; m_drop = 0; m_blk = m_pc;
                m_hit = bus.bp_hit; m_slot = bus.bp_slot; m_tgt = bus.bp_target;
                m_pc = m_hit ? m_tgt : m_pc + AW'(4 * FW);
            end
        end
        if (bus.imem_resp_valid) mem_busy = 0;
        else if (mem_busy) mem_lat--;
        if (acc) begin
            mem_busy = 1;
            mem_addr = bus.imem_req_addr;
            mem_lat  = int'($urandom_range(lat_max, lat_min)) - 1;
        end
    endtask

    task automatic cycle();
        drive();
        @(negedge clk);
        observe();
        @(posedge clk);
        #1;
    endtask

    task automatic check_outputs_zero(input string tag);
        chk({tag, "_req_valid"}, bus.imem_req_valid, 0);
        chk({tag, "_req_addr"}, bus.imem_req_addr, 0);
        chk({tag, "_dec_valid"}, bus.dec_valid, 0);
        chk({tag, "_dec_instr"}, bus.dec_instr, 0);
        chk({tag, "_dec_pc"}, bus.dec_pc, 0);
        chk({tag, "_dec_taken"}, bus.dec_pred_taken, 0);
        chk({tag, "_dec_target"}, bus.dec_pred_target, 0);
        chk({tag, "_count"}, bus.queue_count, 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.imem_req_ready = 0; bus.imem_resp_valid = 0; bus.imem_resp_data = '0;
        bus.redirect_valid = 0; bus.redirect_pc = '0; bus.dec_ready = 0;
        mem_busy = 0;
        model_reset();
        #1;
        check_outputs_zero("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;
        req_log.delete(); dec_log.delete(); mask_log.delete();
    endtask

    initial begin
        p_ready = 100; lat_min = 1; lat_max = 1; p_dec = 100; p_redir = 0; bp_mode = 0;
        force_redir = 0; redir_on_resp = 0; redir_on_req = 0; redir_pc = '0;
        mem_addr = '0; mem_lat = 0;
        #2;
        // Sequential fetch, no predictions
        do_reset();
        repeat (12) cycle();
        chk("t1_nreq", req_log.size() >= 3, 1);
        chk("t1_req0", req_log[0], 32'h0);
        chk("t1_req1", req_log[1], 32'h8);
        chk("t1_req2", req_log[2], 32'h10);
        chk("t1_ndec", dec_log.size() >= 2, 1);
        chk("t1_dec0_pc", dec_log[0].pc, 32'h0);
        chk("t1_dec0_mask", mask_log[0], 2'b11);
        chk("t1_dec1_pc", dec_log[1].pc, 32'h8);
        chk("t1_dec1_taken", dec_log[1].taken, 0);
        // BTB hit at slot 0 of block 0x8
        do_reset();
        bp_mode = 1;
        repeat (12) cycle();
        chk("t2_nreq", req_log.size() >= 3, 1);
        chk("t2_req1", req_log[1], 32'h8);
        chk("t2_req2", req_log[2], 32'h100);
        chk("t2_ndec", dec_log.size() >= 2, 1);
        chk("t2_dec1_pc", dec_log[1].pc, 32'h8);
        chk("t2_dec1_mask", mask_log[1], 2'b01);
        chk("t2_dec1_taken", dec_log[1].taken, 1);
        chk("t2_dec1_target", dec_log[1].tgt, 32'h100);
        // Back-pressure fills the queue, then drains
        do_reset();
        bp_mode = 0; p_dec = 0;
        repeat (20) cycle();
        chk("t3_full_count", bus.queue_count, 8);
        chk("t3_full_no_req", bus.imem_req_valid, 0);
        chk("t3_nreq", req_log.size(), 4);
        p_dec = 100;
        cycle();
        chk("t3_drain_count", bus.queue_count, 6);
        for (int k = 0; k < 10 && req_log.size() < 5; k++) cycle();
        chk("t3_resume", req_log.size() >= 5, 1);
        // Redirect while waiting for a response
        do_reset();
        p_dec = 0; lat_min = 3; lat_max = 3;
        for (int k = 0; k < 50 && !(req_log.size() == 2 && mem_busy); k++) cycle();
        chk("t4_in_wait", req_log.size() == 2 && mem_busy, 1);
        redir_pc = 32'h200; force_redir = 1;
        cycle();
        chk("t4_flushed", bus.queue_count, 0);
        for (int k = 0; k < 30 && req_log.size() < 3; k++) cycle();
        chk("t4_req_after", req_log[2], 32'h200);
        // Redirect coinciding with a response
        do_reset();
        p_dec = 0; lat_min = 1; lat_max = 1;
        for (int k = 0; k < 30 && req_log.size() < 2; k++) cycle();
        redir_pc = 32'h300; redir_on_resp = 1;
        for (int k = 0; k < 20 && redir_on_resp; k++) cycle();
        chk("t5a_fired", redir_on_resp, 0);
        p_dec = 100; dec_log.delete();
        for (int k = 0; k < 40 && dec_log.size() == 0; k++) cycle();
        chk("t5a_first_pc", dec_log[0].pc, 32'h300);
        // Redirect in REQ with ready in the same cycle
        p_dec = 0;
        begin
            int n0 = req_log.size();
            for (int k = 0; k < 30 && req_log.size() < n0 + 2; k++) cycle();
        end
        redir_pc = 32'h400; redir_on_req = 1;
        for (int k = 0; k < 20 && redir_on_req; k++) cycle();
        chk("t5b_fired", redir_on_req, 0);
        p_dec = 100; dec_log.delete();
        for (int k = 0; k < 40 && dec_log.size() == 0; k++) cycle();
        chk("t5b_first_pc", dec_log[0].pc, 32'h400);
        // Asynchronous reset in WAIT with a late response still pending
        do_reset();
        p_dec = 0; lat_min = 6; lat_max = 6;
        for (int k = 0; k < 50 && !(req_log.size() == 2 && mem_busy); k++) cycle();
        chk("t6_in_wait", req_log.size() == 2 && mem_busy && bus.queue_count == 2, 1);
        drive();
        #2;
        rst = 1'b1;
        #1;
        check_outputs_zero("t6_async");
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        req_log.delete(); dec_log.delete(); mask_log.delete();
        p_dec = 100; lat_min = 1; lat_max = 1;
        for (int k = 0; k < 40 && dec_log.size() == 0; k++) cycle();
        chk("t6_first_req", req_log[0], 32'h0);
        chk("t6_first_pc", dec_log[0].pc, 32'h0);
        chk("t6_first_instr", dec_log[0].instr, instr_of(32'h0));
        // Randomized traffic
        do_reset();
        bp_mode = 2; p_ready = 60; lat_min = 1; lat_max = 4; p_dec = 50; p_redir = 20;
        repeat (1500) cycle();
        chk("t7_progress", dec_log.size() > 100, 1);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/fetch_queue_unit.md
Name: fetch_queue_unit

Overview:
- Parametrised N-wide instruction fetch stage. Owns the PC, issues block requests to a handshaked instruction memory with variable latency, and applies BTB predictions to truncate each fetch block.
- Buffers fetched instructions in a fetch queue and presents up to FETCH_WIDTH instructions per cycle to decode under valid/ready.
- Sits between branch prediction/instruction memory and decode. Takes a redirect from the backend on mispredict or flush.

Parameters:
ADDR_WIDTH, 32, PC/address width
DATA_WIDTH, 32, instruction width
FETCH_WIDTH, 2, instructions per fetch block and per decode transfer (power of 2, >=2)
QUEUE_DEPTH, 8, fetch queue entries (power of 2, >= 2*FETCH_WIDTH)
RESET_PC, 0, PC after reset

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
imem_req_valid  out  1  fetch request valid
imem_req_ready  in  1  memory accepts request
imem_req_addr  out  ADDR_WIDTH  block start address
imem_resp_valid  in  1  response data valid
imem_resp_data  in  FETCH_WIDTH*DATA_WIDTH  slot i at [i*DATA_WIDTH +: DATA_WIDTH], slot i = addr+4i
bp_hit  in  1  BTB predicts taken branch in block at imem_req_addr (combinational lookup)
bp_slot  in  max(1,$clog2(FETCH_WIDTH))  slot index of predicted-taken branch
bp_target  in  ADDR_WIDTH  predicted target
redirect_valid  in  1  backend redirect/flush
redirect_pc  in  ADDR_WIDTH  new fetch PC
dec_valid  out  FETCH_WIDTH  lane valid, contiguous from lane 0
dec_ready  in  1  decode accepts all valid lanes
dec_instr  out  FETCH_WIDTH*DATA_WIDTH  lane instructions
dec_pc  out  FETCH_WIDTH*ADDR_WIDTH  lane PCs
dec_pred_taken  out  FETCH_WIDTH  lane predicted taken
dec_pred_target  out  FETCH_WIDTH*ADDR_WIDTH  lane predicted target (0 if not taken)
queue_count  out  $clog2(QUEUE_DEPTH)+1  occupied entries

Behaviour:
- Reset, asynchronous and immediate:
  - pc=RESET_PC, state=IDLE, queue empty, count=0.
  - All outputs 0; imem_req_addr=0 until REQ.
- FSM states: IDLE, REQ, WAIT, DROP.
- IDLE: go to REQ when (QUEUE_DEPTH-count) >= FETCH_WIDTH.
- REQ:
  - Drive imem_req_valid=1, imem_req_addr=pc. Address is held stable until accepted.
  - On imem_req_ready, latch bp_hit/bp_slot/bp_target and block PC.
  - pc <= bp_hit ? bp_target : pc + 4*FETCH_WIDTH (mod 2^ADDR_WIDTH). Go to WAIT.
- WAIT: on imem_resp_valid, enqueue slots 0..K in order and go to IDLE.
  - K=bp_slot if the latched bp_hit is set, else FETCH_WIDTH-1.
  - The entry at slot K gets pred_taken=1 and pred_target=bp_target when hit; all other entries get 0.
  - Entry PC = block PC + 4*slot.
- At most one request outstanding. The space check at IDLE guarantees the queue never overflows.
- Dequeue:
  - dec_valid[i]=(i<count). Lanes are driven from the head entries, registered in the queue, with no added latency.
  - When dec_ready && dec_valid[0], pop min(count,FETCH_WIDTH) entries.
  - Enqueue and dequeue in the same cycle: count += enq-deq.
  - Pointers wrap modulo QUEUE_DEPTH.
  - Empty: dec_valid=0. Full: no new request.
- Redirect has top priority in every state:
  - Queue flushed (count=0, dec_valid=0 next cycle); pc <= redirect_pc.
  - IDLE: stay IDLE.
  - REQ without ready: request withdrawn, go to IDLE. This is the only legal withdrawal.
  - REQ with ready in the same cycle: request counted as issued, go to DROP.
  - WAIT without resp: go to DROP.
  - WAIT with resp in the same cycle: response discarded, go to IDLE.
  - DROP: stay DROP; pc is updated.
- DROP: the next imem_resp_valid is discarded, then go to IDLE. No enqueue happens in DROP.
- A dequeue in the same cycle as a redirect is ignored (queue cleared).

Optional Feature:
- Macro FETCH_PERF_CNT_EN.
- When defined, adds 32-bit saturating output counters, reset to 0:
  - perf_stall_full: cycles in IDLE with insufficient space.
  - perf_dropped: responses discarded due to redirect.
  - perf_fetched: instructions enqueued.
- When undefined, these ports and their logic are absent and behaviour is otherwise identical.

Test Plan:
- Config FETCH_WIDTH=2, QUEUE_DEPTH=8, RESET_PC=0x0; memory ready=1 with 1-cycle response, dec_ready=1, bp_hit=0 -> requests at 0x0, 0x8, 0x10; decode sees lane pairs (0x0,0x4), (0x8,0xC); dec_pred_taken=0.
- bp_hit=1, bp_slot=0, bp_target=0x100 at request 0x8 -> only instr@0x8 enqueued with dec_pred_taken[0]=1 and target 0x100; dec_valid=2'b01 for that block; next request 0x100.
- dec_ready=0 from reset -> 4 blocks fetched, queue_count=8, imem_req_valid stays 0. Raise dec_ready -> 2 entries drained per cycle; fetch resumes when count<=6.
- redirect_valid with redirect_pc=0x200 while in WAIT -> queue_count=0 next cycle; the following response is not enqueued; next request addr=0x200.
- redirect in the same cycle as imem_resp_valid, and redirect in REQ with imem_req_ready=1 -> no stale entry ever appears on dec_valid; the first decoded PC is the redirect target.
- Assert rst asynchronously mid-WAIT -> outputs 0 immediately without a clock edge; after release, the first request is at 0x0. A late response from before reset is ignored.
